// File: rtl/mode_button_pkg.sv
// Shared types and constants for the button PIO service controller and its arbiter.
package mode_button_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    WAIT,
    SAMP,
    CLR,
    EVT
  } state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mode_button_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter
  import mode_button_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IW-1:0]     grant_idx_o,
  output logic              valid_o
);

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr_i) + k) % NUM_CH;
      if (req_i[c]) begin
        grant_o     = '0;
        grant_o[c]  = 1'b1;
        grant_idx_o = IW'(c);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_button_ctrl.sv
// Avalon-MM master servicing NUM_CH edge-capture button PIOs and keeping a wrapping mode index.
// Optional per-channel post-service lockout is enabled by defining DEBOUNCE_EN.
module mode_button_ctrl
  import mode_button_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int NUM_MODES      = 4,
  parameter int HOLDOFF_CYCLES = 50000,
  localparam int CH_W          = idx_width(NUM_CH),
  localparam int MODE_W        = $clog2(NUM_MODES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        irq_in,
  input  logic [32*NUM_CH-1:0]     readdata_in,
  output logic [1:0]               pio_address,
  output logic [NUM_CH-1:0]        pio_chipselect,
  output logic                     pio_write_n,
  output logic [31:0]              pio_writedata,
  output logic                     event_valid,
  output logic [CH_W-1:0]          event_ch,
  output logic [MODE_W-1:0]        mode,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     init_idx_q, init_idx_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     grant_idx_q, grant_idx_d;
  logic [NUM_CH-1:0]   grant_oh_q, grant_oh_d;
  logic                capt_q, capt_d;
  logic                bus_en_q;
  logic                event_valid_q, event_valid_d;
  logic [CH_W-1:0]     event_ch_q, event_ch_d;
  logic [MODE_W-1:0]   mode_q, mode_d;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   rd_bit0;
  logic [NUM_CH-1:0]   arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_valid;
  logic                unused_rd;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rd
    assign rd_bit0[gi] = readdata_in[32*gi];
  end
  assign unused_rd = ^readdata_in;

`ifdef DEBOUNCE_EN
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_holdoff
    logic [HW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == EVT && grant_idx_q == CH_W'(gi)) begin
        cnt_d = HW'(HOLDOFF_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - HW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign eligible[gi] = (cnt_q == '0);
  end
`else
  logic unused_holdoff;
  assign eligible       = '1;
  assign unused_holdoff = (HOLDOFF_CYCLES != 0);
`endif

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(CH_W)) u_arb (
    .req_i       (irq_in & eligible),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  always_comb begin
    state_d        = state_q;
    init_idx_d     = init_idx_q;
    rr_ptr_d       = rr_ptr_q;
    grant_idx_d    = grant_idx_q;
    grant_oh_d     = grant_oh_q;
    capt_d         = capt_q;
    event_valid_d  = 1'b0;
    event_ch_d     = event_ch_q;
    mode_d         = mode_q;
    pio_chipselect = '0;
    pio_address    = PIO_ADDR_DATA;
    pio_write_n    = 1'b1;
    pio_writedata  = 32'h0;

    case (state_q)
      INIT: begin
        // The bus stays quiet for the first cycle after reset so an abandoned access is dropped.
        if (bus_en_q) begin
          pio_chipselect = NUM_CH'(1) << init_idx_q;
          pio_address    = PIO_ADDR_MASK;
          pio_write_n    = 1'b0;
          pio_writedata  = 32'h1;
          if (init_idx_q == CH_W'(NUM_CH - 1)) begin
            init_idx_d = '0;
            state_d    = IDLE;
          end else begin
            init_idx_d = init_idx_q + CH_W'(1);
          end
        end
      end
      IDLE: begin
        if (arb_valid) begin
          grant_idx_d = arb_idx;
          grant_oh_d  = arb_grant;
          state_d     = RD;
        end
      end
      RD: begin
        pio_chipselect = grant_oh_q;
        pio_address    = PIO_ADDR_EDGE;
        state_d        = WAIT;
      end
      WAIT: begin
        pio_address = PIO_ADDR_EDGE;
        state_d     = SAMP;
      end
      SAMP: begin
        pio_address = PIO_ADDR_EDGE;
        capt_d      = rd_bit0[grant_idx_q];
        state_d     = CLR;
      end
      CLR: begin
        pio_chipselect = grant_oh_q;
        pio_address    = PIO_ADDR_EDGE;
        pio_write_n    = 1'b0;
        // Event outputs are loaded on entry to EVT so they are visible during the pulse.
        event_valid_d  = capt_q;
        if (capt_q) begin
          event_ch_d = grant_idx_q;
          mode_d     = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
        end
        state_d = EVT;
      end
      EVT: begin
        rr_ptr_d = (grant_idx_q == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_q + CH_W'(1);
        state_d  = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_oh_q    <= '0;
      capt_q        <= 1'b0;
      bus_en_q      <= 1'b0;
      event_valid_q <= 1'b0;
      event_ch_q    <= '0;
      mode_q        <= '0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_oh_q    <= grant_oh_d;
      capt_q        <= capt_d;
      bus_en_q      <= 1'b1;
      event_valid_q <= event_valid_d;
      event_ch_q    <= event_ch_d;
      mode_q        <= mode_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_ch    = event_ch_q;
  assign mode        = mode_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mode_button_ctrl.sv
// Self-checking bench for mode_button_ctrl with a behavioural edge-capture PIO slave per channel.
module tb_mode_button_ctrl;

  localparam int N = 4;
  localparam int M = 4;
  localparam int H = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    irq_in;
  logic [32*N-1:0] readdata_in;
  logic [1:0]      pio_address;
  logic [N-1:0]    pio_chipselect;
  logic            pio_write_n;
  logic [31:0]     pio_writedata;
  logic            event_valid;
  logic [1:0]      event_ch;
  logic [1:0]      mode;
  logic            busy;

  always #5 clk = ~clk;

  mode_button_ctrl #(.NUM_CH(N), .NUM_MODES(M), .HOLDOFF_CYCLES(H)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .readdata_in    (readdata_in),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .event_valid    (event_valid),
    .event_ch       (event_ch),
    .mode           (mode),
    .busy           (busy)
  );

  // ---------------- PIO slave models ----------------
  logic [N-1:0] edge_q, mask_q, spur_q;
  logic [N-1:0] hold, set_edge, set_spur;
  logic [31:0]  rd_q [N];
  int           cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        edge_q[i] <= 1'b0;
        mask_q[i] <= 1'b0;
        spur_q[i] <= 1'b0;
        rd_q[i]   <= 32'h0;
      end else begin
        if (pio_chipselect[i] && !pio_write_n && pio_address == 2'd2)
          mask_q[i] <= pio_writedata[0];
        if (pio_chipselect[i] && !pio_write_n && pio_address == 2'd3) begin
          edge_q[i] <= hold[i] | set_edge[i];
          spur_q[i] <= set_spur[i];
        end else begin
          edge_q[i] <= edge_q[i] | set_edge[i];
          spur_q[i] <= spur_q[i] | set_spur[i];
        end
        if (pio_chipselect[i] && pio_write_n)
          rd_q[i] <= (pio_address == 2'd3) ? {31'b0, edge_q[i]} :
                     (pio_address == 2'd2) ? {31'b0, mask_q[i]} : 32'h0;
      end
    end
  end

  assign irq_in = (edge_q & mask_q) | spur_q;
  for (genvar gi = 0; gi < N; gi++) begin : g_rd
    assign readdata_in[32*gi +: 32] = rd_q[gi];
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: service order is the cyclic scan of pending channels from the pointer.
  typedef struct { int ch; int md; } exp_t;
  exp_t exp_q[$];
  int   m_ptr  = 0;
  int   m_mode = 0;

  function automatic int next_grant(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic build_expect(input logic [N-1:0] e, input logic [N-1:0] s);
    logic [N-1:0] pending;
    int g;
    pending = e | s;
    while (pending != '0) begin
      g = next_grant(pending, m_ptr);
      if (e[g]) begin
        m_mode = (m_mode + 1) % M;
        exp_q.push_back('{ch: g, md: m_mode});
      end
      m_ptr = (g + 1) % N;
      pending[g] = 1'b0;
    end
  endtask

  task automatic pulse(input logic [N-1:0] e, input logic [N-1:0] s);
    set_edge = e;
    set_spur = s;
    @(posedge clk);
    #1;
    set_edge = '0;
    set_spur = '0;
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    x = exp_q.pop_front();
    check({tag, "_ch"}, 32'(event_ch), x.ch);
    check({tag, "_mode"}, 32'(mode), x.md);
    $display("event ch=%0d mode=%0d (expected ch=%0d mode=%0d)", event_ch, mode, x.ch, x.md);
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (event_valid) begin
        if (exp_q.size() == 0) check("extra_event", 32'(event_valid), 0);
        else pop_check("drain");
      end
      if (exp_q.size() == 0 && !busy && irq_in == '0) done = 1'b1;
    end
    check("drain_done", 32'(done), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(input int budget);
    bit found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (pio_chipselect != '0) found = 1'b1;
    end
    check("init_start", 32'(found), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] cs;
    logic [1:0]   addr;
    bit           addr_chk;
    logic         wn;
    logic [31:0]  wd;
    logic         ev;
    logic         bsy;
  } row_t;

  row_t tbl [19];

  function automatic row_t mk(input logic [N-1:0] cs, input logic [1:0] a, input bit ac,
                              input logic wn, input logic [31:0] wd, input logic ev, input logic b);
    row_t r;
    r.cs = cs; r.addr = a; r.addr_chk = ac; r.wn = wn; r.wd = wd; r.ev = ev; r.bsy = b;
    return r;
  endfunction

  task automatic run_rows(input int first, input int last, input bit aligned);
    for (int r = first; r <= last; r++) begin
      if (r != first || !aligned) @(negedge clk);
      check($sformatf("row%0d_cs", r), 32'(pio_chipselect), 32'(tbl[r].cs));
      check($sformatf("row%0d_wn", r), 32'(pio_write_n), 32'(tbl[r].wn));
      check($sformatf("row%0d_wd", r), pio_writedata, tbl[r].wd);
      check($sformatf("row%0d_ev", r), 32'(event_valid), 32'(tbl[r].ev));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
      if (tbl[r].addr_chk)
        check($sformatf("row%0d_addr", r), 32'(pio_address), 32'(tbl[r].addr));
      if (tbl[r].ev && exp_q.size() > 0) pop_check($sformatf("row%0d", r));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    // INIT mask writes, then IDLE
    for (int k = 0; k < 4; k++) tbl[k] = mk(N'(1) << k, 2'd2, 1, 1'b0, 32'h1, 1'b0, 1'b1);
    tbl[4]  = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    // genuine ch0 service: IDLE, RD, WAIT, SAMP, CLR, EVT, IDLE
    tbl[5]  = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[6]  = mk(4'b0001, 2'd3, 1, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[7]  = mk(4'b0000, 2'd3, 1, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[8]  = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[9]  = mk(4'b0001, 2'd3, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    tbl[10] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b1, 1'b1);
    tbl[11] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    // spurious ch2 service: clear still written, no event
    tbl[12] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[13] = mk(4'b0100, 2'd3, 1, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[14] = mk(4'b0000, 2'd3, 1, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[15] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[16] = mk(4'b0100, 2'd3, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    tbl[17] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[18] = mk(4'b0000, 2'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0);

    reset = 1'b1; hold = '0; set_edge = '0; set_spur = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(pio_chipselect), 0);
    check("rst_wn", 32'(pio_write_n), 1);
    check("rst_ev", 32'(event_valid), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_evch", 32'(event_ch), 0);
    check("rst_busy", 32'(busy), 1);
    @(posedge clk); #1 reset = 1'b0;

    // partial INIT, then reset mid-sequence
    wait_cs(10);
    check("init1_cs0", 32'(pio_chipselect), 32'h1);
    @(negedge clk);
    check("init1_cs1", 32'(pio_chipselect), 32'h2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_cs", 32'(pio_chipselect), 0);
    check("midrst_busy", 32'(busy), 1);
    @(posedge clk); #1 reset = 1'b0;

    wait_cs(10);
    run_rows(0, 4, 1'b1);
    @(posedge clk); #1;

    // single genuine irq on ch0: latency, bus sequence, mode 0->1
    build_expect(4'b0001, 4'b0000);
    pulse(4'b0001, 4'b0000);
    run_rows(5, 11, 1'b0);
    @(posedge clk); #1;

    // spurious irq on ch2
    build_expect(4'b0000, 4'b0100);
    pulse(4'b0000, 4'b0100);
    run_rows(12, 18, 1'b0);
    check("spur_mode", 32'(mode), 32'(m_mode));
    @(posedge clk); #1;

    // pointer after spurious ch2 must be 3: ch3 served before ch0
    build_expect(4'b1001, 4'b0000);
    pulse(4'b1001, 4'b0000);
    drain(100);

    // held irqs 1011: strict round-robin rotation with mode wrap
    begin
      int g;
      for (int k = 0; k < 4; k++) begin
        g = next_grant(4'b1011, m_ptr);
        m_mode = (m_mode + 1) % M;
        exp_q.push_back('{ch: g, md: m_mode});
        m_ptr = (g + 1) % N;
      end
    end
    hold = 4'b1011;
    pulse(4'b1011, 4'b0000);
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      if (event_valid) begin
        pop_check("held");
        got++;
      end
    end
    check("held_events", 32'(got), 4);
    hold = '0;
    exp_q.delete();
    build_expect(4'b1011, 4'b0000);
    drain(200);

    // randomized bursts of genuine and spurious irqs
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] e, s;
      e = N'($urandom_range(0, 15));
      s = N'($urandom_range(0, 15)) & ~e;
      if ((e | s) == '0) e = 4'b0001;
      build_expect(e, s);
      pulse(e, s);
      drain(200);
    end

`ifdef DEBOUNCE_EN
    // lockout: ch1 re-asserted 3 cycles after its EVT waits; ch0 goes first
    begin
      int t_evt, t_ch0, t_ch1;
      t_evt = -1; t_ch0 = -1; t_ch1 = -1;
      pulse(4'b0010, 4'b0000);
      for (int c = 0; c < 50 && t_evt < 0; c++) begin
        @(negedge clk);
        if (event_valid) t_evt = cyc_cnt;
      end
      check("db_first_seen", 32'(t_evt >= 0), 1);
      m_mode = (m_mode + 1) % M;
      check("db_first_mode", 32'(mode), 32'(m_mode));
      for (int c = 0; c < 20 && cyc_cnt < t_evt + 3; c++) @(posedge clk);
      #1;
      pulse(4'b0011, 4'b0000);
      for (int c = 0; c < 100 && t_ch1 < 0; c++) begin
        @(negedge clk);
        if (event_valid && event_ch == 2'd0 && t_ch0 < 0) t_ch0 = cyc_cnt;
        if (event_valid && event_ch == 2'd1) t_ch1 = cyc_cnt;
      end
      check("db_ch0_seen", 32'(t_ch0 >= 0), 1);
      check("db_ch0_first", 32'(t_ch0 < t_ch1), 1);
      check("db_ch1_not_early", 32'(t_ch1 - t_evt >= H + 5), 1);
      check("db_ch1_not_late", 32'(t_ch1 - t_evt <= H + 8), 1);
      m_mode = (m_mode + 2) % M;
      check("db_mode", 32'(mode), 32'(m_mode));
      $display("debounce ch1 events at %0d and %0d, ch0 at %0d", t_evt, t_ch1, t_ch0);
      drain(50);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
